uart_rx_cfg: RTL

Parametrised successor to the fixed 8N1 UART receiver. Frame format is configurable: data bits, parity and stop bits. It adds an input synchroniser, a false-start filter, parity and framing error flags, and a valid/ready output handshake with overrun detection. It sits between the board RX pin and the console-mux byte path.

---
 rtl/uart_rx_cfg.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg -- configurable UART receiver
//
// Receives asynchronous serial frames in this order: a start bit, DATA_BITS
// data bits (LSB first), an optional parity bit and STOP_BITS stop bits.
// Each completed word is presented on a valid/ready handshake together with
// its parity and framing error flags. A word that completes while the
// consumer is still holding the previous one is dropped, and the sticky
// overrun flag is set.
//
// Parameters
//   CLK_PER_BIT  clocks per bit period (>= 4, or >= 6 with majority voting)
//   DATA_BITS    data bits per frame, 5..9
//   PARITY       0 = none, 1 = odd, 2 = even
//   STOP_BITS    1 or 2
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   serial_line  RX line, idle high, asynchronous to clk
//   data         received word; stable while valid is high
//   valid        a word is available in data
//   ready        the consumer takes data when valid && ready
//   parity_err   parity mismatch for the word in data (always 0 when PARITY=0)
//   frame_err    a stop bit of the word in data was sampled low
//   overrun      sticky; a frame completed while valid=1 and ready=0
//   busy         receiver is inside a frame (any state other than IDLE)
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every bit is the 2-of-3 majority of
//                        the synchronised line at mid-1, mid and mid+1. The
//                        decision is taken at mid+1, so completion comes one
//                        clock later. CLK_PER_BIT must then be 6 or more.
//                        When undefined, each bit is a single sample at mid-bit.
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 100,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_line,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_DLY = 1;
`else
  localparam int SAMPLE_DLY = 0;
`endif

  // The start bit is judged half a bit after the falling edge; every later
  // bit is judged one full bit period after the previous decision, so all
  // decisions stay centred on their bits.
  localparam logic [CW-1:0] START_TICK = CW'(CLK_PER_BIT / 2 - 1 + SAMPLE_DLY);
  localparam logic [CW-1:0] BIT_TICK   = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD    = (PARITY == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 rx_p0;
  logic                 rx_s;
  logic                 rx_prev;
  logic [1:0]           fill;
  logic                 armed;
  logic                 bit_s;
  logic                 start_edge;
  logic                 tick;
  logic                 complete;
  logic                 stop_bad;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_pend;
  logic                 pe_pend;

  // -------------------------------------------------------------------------
  // Input synchroniser and falling-edge detection
  // -------------------------------------------------------------------------
  // The synchroniser flops come out of reset high, so for the first two
  // clocks rx_s does not reflect the pin. armed only goes high once a real
  // high level has been seen through the synchroniser; a line that is low at
  // reset release therefore has to go high and low again before a start
  // can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_p0   <= serial_line;
      rx_s    <= rx_p0;
      rx_prev <= rx_s;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && rx_s) armed <= 1'b1;
    end
  end

  assign start_edge = armed && rx_prev && !rx_s;

`ifdef UART_RX_MAJORITY_EN
  // One more history tap: at the decision clock (mid+1) rx_s, rx_prev and
  // rx_prev2 hold the line at mid+1, mid and mid-1.
  logic rx_prev2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev2 <= 1'b1;
    else        rx_prev2 <= rx_prev;
  end

  assign bit_s = (rx_s & rx_prev) | (rx_s & rx_prev2) | (rx_prev & rx_prev2);
`else
  assign bit_s = rx_s;
`endif

  // -------------------------------------------------------------------------
  // Frame sequencer
  // -------------------------------------------------------------------------
  assign tick     = (state == S_START) ? (cnt == START_TICK) : (cnt == BIT_TICK);
  assign complete = (state == S_STOP) && tick && (idx == LAST_STOP);
  assign stop_bad = fe_pend | ~bit_s;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      fe_pend <= 1'b0;
    end else begin
      cnt <= (state == S_IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (start_edge) begin
            state   <= S_START;
            fe_pend <= 1'b0;
          end
        end
        S_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (tick) state <= bit_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (tick) begin
            shreg <= {bit_s, shreg[DATA_BITS-1:1]};
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (tick) state <= S_STOP;
        end
        S_STOP: begin
          if (tick) begin
            if (!bit_s) fe_pend <= 1'b1;
            // Leaving at the middle of the last stop bit lets the next start
            // edge be caught even when frames are sent back to back.
            if (idx == LAST_STOP) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Parity check
  // -------------------------------------------------------------------------
  generate
    if (PARITY != 0) begin : g_parity
      // The shift register already holds every data bit when the parity bit
      // is judged. A mismatch is any XOR that differs from the odd/even target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      pe_pend <= 1'b0;
        else if (state == S_PAR && tick) pe_pend <= (^shreg) ^ bit_s ^ PAR_ODD;
      end
    end else begin : g_no_parity
      assign pe_pend = 1'b0;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output holding register and handshake
  // -------------------------------------------------------------------------
  // A completion in the same clock as an accept replaces the word without an
  // overrun. A completion while the held word is still pending is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete) begin
      if (!valid || ready) begin
        data       <= shreg;
        parity_err <= pe_pend;
        frame_err  <= stop_bad;
        valid      <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
